// File: rtl/jk_fsm_pkg.sv
// Shared definitions for the JK on/off machine bank: state encoding and lock counter sizing.
package jk_fsm_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_e;

    // Width of a counter that must hold values 0..dwell, never narrower than one bit.
    function automatic int unsigned lock_w(input int unsigned dwell);
        int unsigned w;
        w = $clog2(dwell + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/jk_fsm_chan.sv
// One OFF/ON channel with J/K control, dwell lockout and registered edge pulses.
// Optional saturating transition counter is built when JK_FSM_BANK_CNT_EN is defined.
module jk_fsm_chan
    import jk_fsm_pkg::*;
#(
    parameter int unsigned DWELL   = 0,
    parameter logic        RST_BIT = 1'b0,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          j,
    input  logic          k,
    output logic          out,
    output logic          rise,
    output logic          fall,
`ifdef JK_FSM_BANK_CNT_EN
    output logic [CW-1:0] tcount,
`endif
    output logic          busy
);

    localparam int unsigned LW = lock_w(DWELL);

    state_e        state_q, state_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;
    logic          accept;

    // Next state: transitions only when enabled and out of lockout.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = en && (lock_q == '0);
        if (lock_q != '0) begin
            lock_d = lock_q - LW'(1);
        end
        unique case (state_q)
            ST_OFF: begin
                if (accept && j) begin
                    state_d = ST_ON;
                    rise_d  = 1'b1;
                    lock_d  = LW'(DWELL);
                end
            end
            ST_ON: begin
                if (accept && k) begin
                    state_d = ST_OFF;
                    fall_d  = 1'b1;
                    lock_d  = LW'(DWELL);
                end
            end
            default: state_d = state_q;
        endcase
        busy_d = (lock_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_e'(RST_BIT);
            lock_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = state_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef JK_FSM_BANK_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating count of accepted transitions.
    always_comb begin
        cnt_d = cnt_q;
        if ((rise_d || fall_d) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tcount = cnt_q;
`endif

endmodule

// File: rtl/jk_fsm_bank.sv
// Bank of NCH independent J/K on/off channels sharing enable and reset.
// Define JK_FSM_BANK_CNT_EN to add per-channel saturating transition counters (tcount port).
module jk_fsm_bank
    import jk_fsm_pkg::*;
#(
    parameter int unsigned    NCH     = 4,
    parameter int unsigned    DWELL   = 0,
    parameter logic [NCH-1:0] RST_VAL = '0,
    parameter int unsigned    CW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NCH-1:0]    j,
    input  logic [NCH-1:0]    k,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    rise,
    output logic [NCH-1:0]    fall,
`ifdef JK_FSM_BANK_CNT_EN
    output logic [NCH*CW-1:0] tcount,
`endif
    output logic [NCH-1:0]    busy
);

    for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
        jk_fsm_chan #(
            .DWELL  (DWELL),
            .RST_BIT(RST_VAL[i]),
            .CW     (CW)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .j     (j[i]),
            .k     (k[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
`ifdef JK_FSM_BANK_CNT_EN
            .tcount(tcount[i*CW +: CW]),
`endif
            .busy  (busy[i])
        );
    end

endmodule

// File: doc/jk_fsm_bank.md
# jk_fsm_bank

Parametrised bank of NCH independent two-state OFF/ON machines with J/K control, built as the multi-channel successor to the single-channel JK state machine. It adds:
- a per-channel reset value;
- a global enable;
- a minimum-dwell lockout after each transition;
- registered rise/fall event pulses;
- optional saturating transition counters.

It sits between raw control strobes and downstream logic that needs a clean, rate-limited on/off level per channel.

## Interface
- NCH, 4, number of channels (≥1)
- DWELL, 0, cycles a channel ignores J/K after a transition (0 = no lockout)
- RST_VAL, {NCH{1'b0}}, per-channel state loaded by reset (bit i = channel i; 1 = ON)
- CW, 8, transition counter width (used only with JK_FSM_BANK_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  global enable; when 0, no channel changes state
- j  in  NCH  per-channel turn-on request
- k  in  NCH  per-channel turn-off request
- out  out  NCH  registered state (1 = ON)
- rise  out  NCH  one-cycle pulse, registered; channel entered ON this cycle
- fall  out  NCH  one-cycle pulse, registered; channel entered OFF this cycle
- busy  out  NCH  channel is in dwell lockout
- tcount  out  NCH*CW  per-channel transition counts; channel i occupies [i*CW +: CW]; present only with JK_FSM_BANK_CNT_EN

## Operation
- Each channel has states OFF and ON, plus a lock counter of width max(1, clog2(DWELL+1)).
- Accept condition: en=1 and lock==0.
- Transition rules when accepted:
  - OFF with j=1 -> ON (k ignored).
  - ON with k=1 -> OFF (j ignored).
  - j=k=1 therefore toggles.
  - All other cases hold.
- On an accepted transition, lock loads DWELL.
- Lock decrements by 1 every cycle while nonzero, regardless of en.
- busy = (lock != 0).
- rise[i] is 1 for exactly the cycle after an OFF->ON transition; fall[i] likewise for ON->OFF. Both are 0 otherwise and are never 1 together.
- Channels are fully independent; only en and reset are shared.
- Reset values: out=RST_VAL, rise=0, fall=0, busy=0, every lock=0, tcount=0.
- Reset overrides every other input, including mid-lockout.

## Timing
- Inputs are sampled at rising edge t. out, rise and fall change after edge t, so latency is 1 cycle.
- Dwell example with DWELL=3 and a transition at edge t:
  - busy is 1 during cycles t+1..t+3.
  - Requests at edges t+1, t+2 and t+3 are ignored.
  - The first acceptable request is at edge t+4.
- DWELL=0: a channel can transition on every edge; busy is constantly 0.
- en falling edge: j/k at any edge with en=0 are dropped, not queued.
- Reset released after edge r: the first accepted request is at edge r+1.

## Configuration
- JK_FSM_BANK_CNT_EN defined:
  - Each channel has a CW-bit counter that increments on every accepted transition.
  - The counter saturates at 2^CW−1.
  - It is cleared by reset.
  - The tcount port exists.
- Undefined: no counters are built and the tcount port is absent. All other behaviour is identical.

## Structure
- Shared package jk_fsm_pkg contains:
  - state constants ST_OFF=1'b0 and ST_ON=1'b1;
  - function lock_w(dwell) returning max(1, clog2(dwell+1)).
- One sub-module, jk_fsm_chan:
  - one channel: state, lock counter, rise/fall registers, optional counter;
  - parameters DWELL, RST_BIT, CW.
- jk_fsm_bank instantiates NCH copies of jk_fsm_chan in a generate loop and concatenates their outputs.

## Test plan
- Reset value: NCH=4, RST_VAL=4'b0101; hold reset for 2 cycles -> out=4'b0101; rise, fall and busy = 0.
- Basic J/K: DWELL=0, ch0 OFF.
  - j[0]=1 for one edge -> out[0]=1 next cycle, rise[0] pulses for 1 cycle.
  - k[0]=1 -> out[0]=0, fall[0] pulses for 1 cycle.
  - Other channels unchanged.
- Toggle and dwell: j[1]=k[1]=1 held.
  - DWELL=0 -> out[1] toggles every cycle.
  - DWELL=2 -> out[1] toggles every 3rd cycle, with busy[1]=1 for the 2 cycles after each toggle.
- Enable gating: en=0, j=4'b1111 for 5 cycles -> out unchanged, no pulses. Raise en -> all OFF channels turn ON one cycle later.
- Reset mid-lockout: DWELL=7; transition on ch2, then reset at the 2nd busy cycle -> busy[2]=0 and out[2]=RST_VAL[2]. A request on the first edge after reset is accepted.
- Counter with JK_FSM_BANK_CNT_EN, CW=2: 5 transitions on ch3 -> tcount[3*2 +: 2] reads 1,2,3,3,3 (saturated). Build without the macro -> elaborates with no tcount port.
